// File: rtl/core_seq.sv
// Sequences one weight-stationary tile: weight fetch, weight load, activation stream, flush, drain.
// Latency: every output is registered; a state's first word appears one cycle after entering it.
// Backpressure: only DRAIN waits, on ofifo_valid, with no timeout; start is ignored while busy.
module core_seq #(
    parameter int row         = 8,
    parameter int col         = 8,
    parameter int aw          = 11,
    parameter int ofifo_depth = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [aw-1:0] w_base,
    input  logic [aw-1:0] x_base,
    input  logic [aw-1:0] p_base,
    input  logic [aw-1:0] num_x,
    input  logic          acc_mode,
    input  logic          ofifo_valid,
    output logic [33:0]   inst,
    output logic          busy,
    output logic          done
);

    // Both SRAMs disabled (CEN/WEN high), all strobes low, addresses zero.
    localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

    localparam logic [aw-1:0] ROW_L     = aw'(row);
    localparam logic [aw-1:0] LOAD_LAST = aw'(row + col - 1);
    localparam logic [aw-1:0] DEPTH_L   = aw'(ofifo_depth);
    localparam logic [aw-1:0] ONE       = aw'(1);
    localparam logic [aw-1:0] TWO       = aw'(2);

    // inst bit positions
    localparam int B_ACC   = 33;
    localparam int B_CENP  = 32;
    localparam int B_WENP  = 31;
    localparam int B_AP    = 20;
    localparam int B_CENX  = 19;
    localparam int B_AX    = 7;
    localparam int B_ORD   = 6;
    localparam int B_L0RD  = 3;
    localparam int B_L0WR  = 2;
    localparam int B_EXEC  = 1;
    localparam int B_LOAD  = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WFETCH,
        S_WLOAD,
        S_XRUN,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [aw-1:0] cnt_q, cnt_d;     // per-state cycle counter (k / j)
    logic [aw-1:0] n_q, n_d;         // pmem writes issued in DRAIN
    logic [aw-1:0] r_q, r_d;         // ofifo reads issued in DRAIN
    logic [aw-1:0] wb_q, wb_d;
    logic [aw-1:0] xb_q, xb_d;
    logic [aw-1:0] pb_q, pb_d;
    logic [aw-1:0] nx_q, nx_d;
    logic          acc_q, acc_d;
    logic [33:0]   inst_q, inst_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next state and the instruction word to present on the following cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        r_d     = r_q;
        wb_d    = wb_q;
        xb_d    = xb_q;
        pb_d    = pb_q;
        nx_d    = nx_q;
        acc_d   = acc_q;
        inst_d  = IDLE_WORD;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wb_d    = w_base;
                    xb_d    = x_base;
                    pb_d    = p_base;
                    // OFIFO cannot hold more vectors than its depth.
                    nx_d    = (num_x > DEPTH_L) ? DEPTH_L : num_x;
                    acc_d   = acc_mode;
                    cnt_d   = '0;
                    n_d     = '0;
                    r_d     = '0;
                    state_d = S_WFETCH;
                end
            end

            S_WFETCH: begin
                if (cnt_q < ROW_L) begin
                    inst_d[B_CENX]        = 1'b0;
                    inst_d[B_AX +: aw]    = wb_q + cnt_q;
                end
                // L0 write trails its SRAM read by the one-cycle read latency.
                if (cnt_q >= ONE) inst_d[B_L0WR] = 1'b1;
                if (cnt_q == ROW_L) begin
                    cnt_d   = '0;
                    state_d = S_WLOAD;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

            S_WLOAD: begin
                inst_d[B_LOAD] = 1'b1;
                if (cnt_q < ROW_L) inst_d[B_L0RD] = 1'b1;
                if (cnt_q == LOAD_LAST) begin
                    cnt_d   = '0;
                    state_d = (nx_q != '0) ? S_XRUN : S_DONE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

            S_XRUN: begin
                inst_d[B_ACC] = acc_q;
                if (cnt_q < nx_q) begin
                    inst_d[B_CENX]     = 1'b0;
                    inst_d[B_AX +: aw] = xb_q + cnt_q;
                end
                if (cnt_q >= ONE && cnt_q <= nx_q) inst_d[B_L0WR] = 1'b1;
                if (cnt_q >= TWO) begin
                    inst_d[B_L0RD] = 1'b1;
                    inst_d[B_EXEC] = 1'b1;
                end
                if (cnt_q == nx_q + ONE) begin
                    cnt_d   = '0;
                    state_d = S_FLUSH;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

            S_FLUSH: begin
                inst_d[B_ACC]  = acc_q;
                inst_d[B_EXEC] = 1'b1;
                if (cnt_q == LOAD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end

            S_DRAIN: begin
                // The entry popped last cycle is on the OFIFO output now: store it.
                if (inst_q[B_ORD]) begin
                    inst_d[B_CENP]     = 1'b0;
                    inst_d[B_WENP]     = 1'b0;
                    inst_d[B_AP +: aw] = pb_q + n_q;
                    n_d                = n_q + ONE;
                end
                if (n_q == nx_q) begin
                    state_d = S_DONE;
                end else if (ofifo_valid && (r_q < nx_q)) begin
                    inst_d[B_ORD] = 1'b1;
                    r_d           = r_q + ONE;
                end
            end

            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, counters, latched tile parameters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            r_q     <= '0;
            wb_q    <= '0;
            xb_q    <= '0;
            pb_q    <= '0;
            nx_q    <= '0;
            acc_q   <= 1'b0;
            inst_q  <= IDLE_WORD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            r_q     <= r_d;
            wb_q    <= wb_d;
            xb_q    <= xb_d;
            pb_q    <= pb_d;
            nx_q    <= nx_d;
            acc_q   <= acc_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: reset, weight fetch/load, activation wrap, stalled drain, empty tile, clamp.
// Latency: sample i is taken at the falling edge after the i-th rising edge following start.
// Backpressure: ofifo_valid is driven per sample from a pattern or a constant default.
module tb_core_seq;

    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] w_base, x_base, p_base, num_x;
    logic        acc_mode;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;

    int vecs = 0;
    int errs = 0;

    logic [33:0] tr_inst[$];
    logic        tr_busy[$];
    logic        tr_done[$];
    int          done_idx;
    int          vstart;
    bit          vpat[$];
    bit          vdef;
    int          restart_at;

    core_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .w_base     (w_base),
        .x_base     (x_base),
        .p_base     (p_base),
        .num_x      (num_x),
        .acc_mode   (acc_mode),
        .ofifo_valid(ofifo_valid),
        .inst       (inst),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int idx, input logic [34:0] obs, input logic [34:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, obs, exp);
        end
    endtask

    // Builds an instruction word from individual fields.
    function automatic logic [33:0] w(input bit acc, input bit ord, input bit l0rd, input bit l0wr,
                                      input bit ex, input bit ld, input bit xrd, input logic [10:0] xa,
                                      input bit pwr, input logic [10:0] pa);
        logic [33:0] v;
        v = IDLE_W;
        v[33] = acc;
        if (xrd) begin
            v[19]   = 1'b0;
            v[17:7] = xa;
        end
        if (pwr) begin
            v[32]    = 1'b0;
            v[31]    = 1'b0;
            v[30:20] = pa;
        end
        v[6] = ord;
        v[3] = l0rd;
        v[2] = l0wr;
        v[1] = ex;
        v[0] = ld;
        return v;
    endfunction

    // Expected trace for: w_base=0x010, x_base=0x7FE, num_x=4, p_base=0x100, acc_mode=1,
    // ofifo_valid 1,0,1,1,0,1 from sample 47 on.
    function automatic logic [33:0] exp_a(input int i);
        logic [33:0] e;
        int j;
        int pidx;
        bit ord;
        bit pwr;
        e = IDLE_W;
        if (i >= 1 && i <= 9) begin
            e = w(1'b0, 1'b0, 1'b0, (i >= 2), 1'b0, 1'b0, (i <= 8), 11'(16 + i - 1), 1'b0, 11'h0);
        end else if (i >= 10 && i <= 25) begin
            e = w(1'b0, 1'b0, (i <= 17), 1'b0, 1'b0, 1'b1, 1'b0, 11'h0, 1'b0, 11'h0);
        end else if (i >= 26 && i <= 31) begin
            j = i - 26;
            e = w(1'b1, 1'b0, (j >= 2), (j >= 1 && j <= 4), (j >= 2), 1'b0, (j < 4), 11'(2046 + j),
                  1'b0, 11'h0);
        end else if (i >= 32 && i <= 47) begin
            e = w(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h0, 1'b0, 11'h0);
        end else if (i >= 48) begin
            ord  = (i == 48 || i == 50 || i == 51 || i == 53);
            pwr  = 1'b1;
            case (i)
                49:      pidx = 0;
                51:      pidx = 1;
                52:      pidx = 2;
                54:      pidx = 3;
                default: begin pidx = 0; pwr = 1'b0; end
            endcase
            e = w(1'b0, ord, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0, pwr, 11'(256 + pidx));
        end
        return e;
    endfunction

    // Starts a tile (caller is at a falling edge) and records samples until done or budget.
    task automatic run_tile(input logic [10:0] wb, input logic [10:0] xb, input logic [10:0] pb,
                            input logic [10:0] nx, input logic am, input int budget);
        tr_inst.delete();
        tr_busy.delete();
        tr_done.delete();
        done_idx    = -1;
        w_base      = wb;
        x_base      = xb;
        p_base      = pb;
        num_x       = nx;
        acc_mode    = am;
        ofifo_valid = vdef;
        start       = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            start = (i == restart_at);
            tr_inst.push_back(inst);
            tr_busy.push_back(busy);
            tr_done.push_back(done);
            if (i >= vstart && (i - vstart) < vpat.size()) ofifo_valid = vpat[i - vstart];
            else ofifo_valid = vdef;
            if (done) begin
                done_idx = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int cnt_busy;
        int cnt_bad;
        int cnt_rd;
        int cnt_wr;

        reset       = 1'b1;
        start       = 1'b0;
        w_base      = '0;
        x_base      = '0;
        p_base      = '0;
        num_x       = '0;
        acc_mode    = 1'b0;
        ofifo_valid = 1'b0;
        vstart      = 1 << 30;
        vdef        = 1'b0;
        restart_at  = -1;

        // Reset state, held and just after release.
        repeat (3) @(negedge clk);
        chk("rst_word", 0, {1'b0, inst}, {1'b0, IDLE_W});
        chk("rst_busy_done", 0, 35'({busy, done}), 35'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", 0, {busy, inst}, {1'b0, IDLE_W});

        // Reset in the middle of XRUN (5th XRUN cycle).
        w_base   = 11'h000;
        x_base   = 11'h020;
        p_base   = 11'h000;
        num_x    = 11'd8;
        acc_mode = 1'b1;
        start    = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("xrun_j3", 29, {busy, inst},
            {1'b1, w(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 11'h023, 1'b0, 11'h0)});
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst", 30, {busy, inst}, {1'b0, IDLE_W});
        chk("mid_rst_done", 30, 35'(done), 35'(0));
        reset = 1'b0;
        @(negedge clk);

        // Full tile: weight fetch at 0x010, x wrap at 0x7FE, stalled drain to 0x100.
        vstart = 47;
        vpat   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vdef   = 1'b0;
        run_tile(11'h010, 11'h7FE, 11'h100, 11'd4, 1'b1, 300);
        chk("a_done_idx", 0, 35'(done_idx), 35'(56));
        if (done_idx == 56) begin
            for (int i = 0; i <= 56; i++)
                chk("a_word", i, {tr_busy[i], tr_inst[i]}, {(i <= 55), exp_a(i)});
            cnt_bad = 0;
            for (int i = 0; i <= 56; i++) cnt_bad += int'(tr_done[i]);
            chk("a_done_pulses", 0, 35'(cnt_bad), 35'(1));
        end
        vpat.delete();
        vstart = 1 << 30;

        // Empty tile with weight address wrap: fetch and load only.
        run_tile(11'h7FC, 11'h000, 11'h000, 11'd0, 1'b1, 300);
        chk("b_done_idx", 0, 35'(done_idx), 35'(26));
        cnt_busy = 0;
        cnt_bad  = 0;
        foreach (tr_inst[i]) begin
            cnt_busy += int'(tr_busy[i]);
            if (tr_inst[i][1] || !tr_inst[i][32] || tr_inst[i][33]) cnt_bad++;
        end
        chk("b_busy_cycles", 0, 35'(cnt_busy), 35'(26));
        chk("b_no_exec_pmem", 0, 35'(cnt_bad), 35'(0));
        if (done_idx == 26) begin
            chk("b_wrap_rd", 5, {1'b0, tr_inst[5]},
                {1'b0, w(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h000, 1'b0, 11'h0)});
            chk("b_last_rd", 8, {1'b0, tr_inst[8]},
                {1'b0, w(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h003, 1'b0, 11'h0)});
            chk("b_last_load", 25, {1'b0, tr_inst[25]},
                {1'b0, w(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h0, 1'b0, 11'h0)});
            chk("b_done_word", 26, {tr_busy[26], tr_inst[26]}, {1'b0, IDLE_W});
        end

        // num_x=100 clamps to 64; a second start while busy is ignored; pmem wraps.
        vdef       = 1'b1;
        restart_at = 3;
        run_tile(11'h000, 11'h000, 11'h7F0, 11'd100, 1'b0, 400);
        restart_at = -1;
        chk("c_done_idx", 0, 35'(done_idx), 35'(174));
        cnt_rd = 0;
        cnt_wr = 0;
        foreach (tr_inst[i]) begin
            cnt_rd += int'(tr_inst[i][6]);
            if (!tr_inst[i][32]) begin
                chk("c_pmem_addr", cnt_wr, 35'(tr_inst[i][30:20]), 35'(11'(12'h7F0 + cnt_wr)));
                cnt_wr++;
            end
        end
        chk("c_ofifo_rd_cnt", 0, 35'(cnt_rd), 35'(64));
        chk("c_pmem_wr_cnt", 0, 35'(cnt_wr), 35'(64));
        if (done_idx == 174) begin
            chk("c_first_wr", 109, {1'b0, tr_inst[109]},
                {1'b0, w(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0, 1'b1, 11'h7F0)});
            chk("c_last_wr", 172, {1'b0, tr_inst[172]},
                {1'b0, w(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0, 1'b1, 11'h02F)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
